// File: rtl/audio_pack_pkg.sv
// Shared definitions for the stereo output packer: FSM states, PCM limits and
// a saturating narrower usable by any output stage.
package audio_pack_pkg;

    localparam int DATA_SIZE = 32;
    localparam int PCM_BITS  = 16;

    localparam logic signed [DATA_SIZE-1:0] PCM_MAX = DATA_SIZE'((1 << (PCM_BITS - 1)) - 1);
    localparam logic signed [DATA_SIZE-1:0] PCM_MIN = -PCM_MAX - 1;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } state_t;

    function automatic logic [PCM_BITS-1:0] saturate(input logic signed [DATA_SIZE-1:0] x);
        logic [PCM_BITS-1:0] result;
        if (x > PCM_MAX) begin
            result = {1'b0, {(PCM_BITS - 1){1'b1}}};
        end else if (x < PCM_MIN) begin
            result = {1'b1, {(PCM_BITS - 1){1'b0}}};
        end else begin
            result = x[PCM_BITS-1:0];
        end
        return result;
    endfunction

    function automatic logic is_clipped(input logic signed [DATA_SIZE-1:0] x);
        return (x > PCM_MAX) || (x < PCM_MIN);
    endfunction

endpackage

// File: rtl/audio_pack_pcm_saturate.sv
// One channel of signed-sample to PCM narrowing, with a flag when the value
// had to be clamped.
module pcm_saturate
    import audio_pack_pkg::*;
(
    input  logic signed [DATA_SIZE-1:0] din,
    output logic        [PCM_BITS-1:0]  pcm,
    output logic                        clip
);

    assign pcm  = saturate(din);
    assign clip = is_clipped(din);

endmodule

// File: rtl/audio_pack.sv
// Stereo packer: pops the left/right gain FIFOs together, saturates each
// sample to PCM and writes {left, right} as one word to the output FIFO.
module audio_pack
    import audio_pack_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    output logic                  left_rd_en,
    input  logic                  left_empty,
    input  logic [DATA_SIZE-1:0]  left_din,
    output logic                  right_rd_en,
    input  logic                  right_empty,
    input  logic [DATA_SIZE-1:0]  right_din,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic [2*PCM_BITS-1:0] dout,
    output logic [31:0]           sample_count,
    output logic [15:0]           clip_count,
    output state_t                state
);

    logic [PCM_BITS-1:0] left_sat, right_sat;
    logic [PCM_BITS-1:0] left_pcm, right_pcm;
    logic                left_clip, right_clip;
    logic                pop;
    logic [1:0]          clip_add;
    logic [16:0]         clip_sum;
    logic [15:0]         clip_next;

    pcm_saturate u_sat_left (
        .din  (left_din),
        .pcm  (left_sat),
        .clip (left_clip)
    );

    pcm_saturate u_sat_right (
        .din  (right_din),
        .pcm  (right_sat),
        .clip (right_clip)
    );

    // Both channels pop together or not at all, so pairing can never slip.
    assign pop         = (state == READ) && !left_empty && !right_empty;
    assign left_rd_en  = pop;
    assign right_rd_en = pop;
    assign out_wr_en   = (state == WRITE) && !out_full;
    assign dout        = {left_pcm, right_pcm};

    // Clip counter sticks at all-ones instead of wrapping.
    assign clip_add  = {1'b0, left_clip} + {1'b0, right_clip};
    assign clip_sum  = {1'b0, clip_count} + {15'b0, clip_add};
    assign clip_next = clip_sum[16] ? 16'hFFFF : clip_sum[15:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= READ;
            left_pcm     <= '0;
            right_pcm    <= '0;
            sample_count <= '0;
            clip_count   <= '0;
        end else begin
            case (state)
                READ: begin
                    if (pop) begin
                        left_pcm   <= left_sat;
                        right_pcm  <= right_sat;
                        clip_count <= clip_next;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    if (!out_full) begin
                        sample_count <= sample_count + 32'd1;
                        state        <= READ;
                    end
                end
                default: state <= READ;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_pack.sv
// Directed bench for audio_pack: reset, pairing, clipping, backpressure,
// reset during a pending write, and a randomised stream against a model.
module tb_audio_pack;
    import audio_pack_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        left_rd_en, right_rd_en, out_wr_en;
    logic        left_empty = 1'b1, right_empty = 1'b1, out_full = 1'b0;
    logic [31:0] left_din = '0, right_din = '0;
    logic [31:0] dout;
    logic [31:0] sample_count;
    logic [15:0] clip_count;
    state_t      state;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    audio_pack dut (
        .clock        (clock),
        .reset        (reset),
        .left_rd_en   (left_rd_en),
        .left_empty   (left_empty),
        .left_din     (left_din),
        .right_rd_en  (right_rd_en),
        .right_empty  (right_empty),
        .right_din    (right_din),
        .out_full     (out_full),
        .out_wr_en    (out_wr_en),
        .dout         (dout),
        .sample_count (sample_count),
        .clip_count   (clip_count),
        .state        (state)
    );

    always #5 clock = ~clock;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents one pair, lets it pop on the next edge, then empties both FIFOs.
    task automatic send_pop(input logic [31:0] l, input logic [31:0] r, input logic full);
        left_din    = l;
        right_din   = r;
        left_empty  = 1'b0;
        right_empty = 1'b0;
        out_full    = full;
        tick();
        left_empty  = 1'b1;
        right_empty = 1'b1;
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_sat(input logic [31:0] x);
        int s;
        s = x;
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return x[15:0];
    endfunction

    function automatic int model_clip(input logic [31:0] x);
        int s;
        s = x;
        return ((s > 32767) || (s < -32768)) ? 1 : 0;
    endfunction

    function automatic logic [31:0] gen_sample();
        logic [31:0] bnd[6] = '{32'h00007FFF, 32'h00008000, 32'hFFFF8000,
                                32'hFFFF7FFF, 32'h7FFFFFFF, 32'h80000000};
        int v;
        case ($urandom_range(0, 3))
            0: v = $urandom();
            1: v = int'($urandom_range(0, 80000)) - 40000;
            2: v = bnd[$urandom_range(0, 5)];
            default: v = int'($urandom_range(0, 65535)) - 32768;
        endcase
        return v;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (out_wr_en !== 1'b0 || left_rd_en !== 1'b0 || right_rd_en !== 1'b0) begin
            failures++; $display("FAIL reset_strobes got wr=%b lrd=%b rrd=%b exp 0 0 0", out_wr_en, left_rd_en, right_rd_en); end
        checks++; if (dout !== 32'h0) begin
            failures++; $display("FAIL reset_dout got=%h exp=00000000", dout); end
        checks++; if (sample_count !== 32'd0 || clip_count !== 16'd0) begin
            failures++; $display("FAIL reset_counts got=%0d/%0d exp 0/0", sample_count, clip_count); end
        checks++; if (state !== READ) begin
            failures++; $display("FAIL reset_state got=%0d exp=%0d", state, READ); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        left_din    = 32'h00001234;
        right_din   = 32'hFFFFFF00;
        left_empty  = 1'b0;
        right_empty = 1'b0;
        out_full    = 1'b0;
        #1;
        checks++; if (left_rd_en !== 1'b1 || right_rd_en !== 1'b1 || out_wr_en !== 1'b0) begin
            failures++; $display("FAIL basic_pop got lrd=%b rrd=%b wr=%b exp 1 1 0", left_rd_en, right_rd_en, out_wr_en); end
        tick();
        left_empty  = 1'b1;
        right_empty = 1'b1;
        #1;
        checks++; if (out_wr_en !== 1'b1 || left_rd_en !== 1'b0 || right_rd_en !== 1'b0) begin
            failures++; $display("FAIL basic_write got wr=%b lrd=%b rrd=%b exp 1 0 0", out_wr_en, left_rd_en, right_rd_en); end
        checks++; if (dout !== 32'h1234FF00) begin
            failures++; $display("FAIL basic_dout got=%h exp=1234ff00", dout); end
        checks++; if (clip_count !== 16'd0) begin
            failures++; $display("FAIL basic_clip got=%0d exp=0", clip_count); end
        tick();
        checks++; if (sample_count !== 32'd1 || out_wr_en !== 1'b0 || state !== READ) begin
            failures++; $display("FAIL basic_after got cnt=%0d wr=%b st=%0d exp 1 0 0", sample_count, out_wr_en, state); end
    endtask

    task automatic test_clip();
        send_pop(32'd40000, -32'sd40000, 1'b0);
        checks++; if (dout !== 32'h7FFF8000 || clip_count !== 16'd2) begin
            failures++; $display("FAIL clip_both got=%h/%0d exp 7fff8000/2", dout, clip_count); end
        tick();
        send_pop(-32'sd32768, 32'd32767, 1'b0);
        checks++; if (dout !== 32'h80007FFF || clip_count !== 16'd2) begin
            failures++; $display("FAIL clip_boundary got=%h/%0d exp 80007fff/2", dout, clip_count); end
        tick();
        send_pop(32'd32768, -32'sd32769, 1'b0);
        checks++; if (dout !== 32'h7FFF8000 || clip_count !== 16'd4) begin
            failures++; $display("FAIL clip_just_over got=%h/%0d exp 7fff8000/4", dout, clip_count); end
        tick();
        checks++; if (sample_count !== 32'd4) begin
            failures++; $display("FAIL clip_count_pairs got=%0d exp=4", sample_count); end
    endtask

    task automatic test_pairing();
        int stray = 0;
        left_din    = 32'd5;
        left_empty  = 1'b0;
        right_empty = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (left_rd_en !== 1'b0 || right_rd_en !== 1'b0) stray++;
            tick();
        end
        checks++; if (stray !== 0) begin
            failures++; $display("FAIL pair_hold got %0d pop cycles exp 0", stray); end
        right_din   = -32'sd5;
        right_empty = 1'b0;
        #1;
        checks++; if (left_rd_en !== 1'b1 || right_rd_en !== 1'b1) begin
            failures++; $display("FAIL pair_release got lrd=%b rrd=%b exp 1 1", left_rd_en, right_rd_en); end
        tick();
        left_empty  = 1'b1;
        right_empty = 1'b1;
        #1;
        checks++; if (out_wr_en !== 1'b1 || dout !== 32'h0005FFFB) begin
            failures++; $display("FAIL pair_write got wr=%b dout=%h exp 1 0005fffb", out_wr_en, dout); end
        tick();
        checks++; if (sample_count !== 32'd5) begin
            failures++; $display("FAIL pair_count got=%0d exp=5", sample_count); end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        send_pop(32'h00000100, 32'h00000200, 1'b1);
        left_din    = 32'h0000DEAD;
        right_din   = 32'h0000BEEF;
        left_empty  = 1'b0;
        right_empty = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (out_wr_en !== 1'b0 || left_rd_en !== 1'b0 || right_rd_en !== 1'b0 ||
                dout !== 32'h01000200 || state !== WRITE) bad++;
            tick();
        end
        checks++; if (bad !== 0) begin
            failures++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
        out_full    = 1'b0;
        left_empty  = 1'b1;
        right_empty = 1'b1;
        #1;
        checks++; if (out_wr_en !== 1'b1 || dout !== 32'h01000200) begin
            failures++; $display("FAIL bp_release got wr=%b dout=%h exp 1 01000200", out_wr_en, dout); end
        tick();
        checks++; if (sample_count !== 32'd6 || state !== READ || out_wr_en !== 1'b0) begin
            failures++; $display("FAIL bp_after got cnt=%0d st=%0d wr=%b exp 6 0 0", sample_count, state, out_wr_en); end
    endtask

    task automatic test_reset_mid_write();
        send_pop(32'd70000, 32'd1, 1'b1);
        checks++; if (dout !== 32'h7FFF0001 || clip_count !== 16'd5 || out_wr_en !== 1'b0) begin
            failures++; $display("FAIL rmw_pending got=%h/%0d wr=%b exp 7fff0001/5 0", dout, clip_count, out_wr_en); end
        out_full = 1'b0;
        #1;
        checks++; if (out_wr_en !== 1'b1) begin
            failures++; $display("FAIL rmw_wr_high got=%b exp=1", out_wr_en); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (out_wr_en !== 1'b0 || dout !== 32'h0 || sample_count !== 32'd0 ||
                      clip_count !== 16'd0 || state !== READ) begin
            failures++; $display("FAIL rmw_async got wr=%b dout=%h cnt=%0d clip=%0d st=%0d exp 0 0 0 0 0",
                                 out_wr_en, dout, sample_count, clip_count, state); end
        tick();
        reset = 1'b0;
        send_pop(32'd7, 32'd8, 1'b0);
        checks++; if (out_wr_en !== 1'b1 || dout !== 32'h00070008) begin
            failures++; $display("FAIL rmw_next got wr=%b dout=%h exp 1 00070008", out_wr_en, dout); end
        tick();
        checks++; if (sample_count !== 32'd1 || clip_count !== 16'd0) begin
            failures++; $display("FAIL rmw_next_count got=%0d/%0d exp 1/0", sample_count, clip_count); end
    endtask

    task automatic test_stream();
        logic [31:0] lq[$];
        logic [31:0] rq[$];
        logic [31:0] l, r, d, exp_word;
        logic        lp, rp, wr;
        int          clips = 0;
        int          written = 0;
        int          cycles = 0;
        int          pair_err = 0;
        int          data_err = 0;

        reset = 1'b1;
        #1;
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 1000; i++) begin
            l = gen_sample();
            r = gen_sample();
            lq.push_back(l);
            rq.push_back(r);
            exp_q.push_back({model_sat(l), model_sat(r)});
            clips += model_clip(l) + model_clip(r);
        end

        while (written < 1000 && cycles < 20000) begin
            left_empty  = (lq.size() == 0) || ($urandom_range(0, 3) == 0);
            right_empty = (rq.size() == 0) || ($urandom_range(0, 3) == 0);
            left_din    = (lq.size() != 0) ? lq[0] : $urandom();
            right_din   = (rq.size() != 0) ? rq[0] : $urandom();
            out_full    = ($urandom_range(0, 2) == 0);
            @(negedge clock);
            lp = left_rd_en;
            rp = right_rd_en;
            wr = out_wr_en;
            d  = dout;
            if (lp !== rp || (lp && (left_empty || right_empty))) pair_err++;
            tick();
            if (lp === 1'b1 && lq.size() != 0) void'(lq.pop_front());
            if (rp === 1'b1 && rq.size() != 0) void'(rq.pop_front());
            if (wr === 1'b1) begin
                written++;
                exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
                checks++; if (d !== exp_word) begin
                    failures++; data_err++;
                    if (data_err <= 10) $display("FAIL stream_word #%0d got=%h exp=%h", written, d, exp_word);
                end
            end
            cycles++;
        end
        left_empty  = 1'b1;
        right_empty = 1'b1;
        out_full    = 1'b0;

        checks++; if (written < 1000) begin
            failures++; $display("FAIL stream_timeout got %0d words exp 1000", written); end
        checks++; if (pair_err !== 0) begin
            failures++; $display("FAIL stream_pairing got %0d bad pops exp 0", pair_err); end
        checks++; if (sample_count !== 32'd1000) begin
            failures++; $display("FAIL stream_samples got=%0d exp=1000", sample_count); end
        checks++; if (clip_count !== 16'(clips)) begin
            failures++; $display("FAIL stream_clips got=%0d exp=%0d", clip_count, clips); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_pairing();
        test_backpressure();
        test_reset_mid_write();
        test_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
